per_sft_rst_seq: RTL

PER_SFT_RST_SEQ -- requirements
Module: per_sft_rst_seq

---
 rtl/per_sft_rst_seq.sv | 103 ++++++++++
 1 files changed

// File: rtl/per_sft_rst_seq.sv
// Peripheral software-reset sequencer: holds sft_rst_n low for a minimum time,
// waits for downstream clocks to settle after release, then pulses rst_done.
module per_sft_rst_seq #(
  parameter int unsigned MIN_RST_CYCLES = 4,
  parameter int unsigned RELEASE_WAIT   = 2
) (
  input  logic i_clk,
  input  logic sys_rst_n,
  input  logic rst_req,
  input  logic per_ker_clk_req_in,
  input  logic testmode,
  output logic sft_rst_n,
  output logic ker_clk_req,
  output logic rst_busy,
  output logic rst_done
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ASSERT  = 2'd1,
    RELEASE = 2'd2,
    DONE    = 2'd3
  } state_t;

  localparam logic [7:0] MIN_LOAD = 8'(MIN_RST_CYCLES - 1);
  localparam logic [7:0] REL_LOAD = 8'(RELEASE_WAIT - 1);

  state_t     r_state;
  state_t     w_state_nxt;
  logic [7:0] r_cnt;
  logic [7:0] w_cnt_nxt;
  logic       r_sft_rst_n;
  logic       r_busy;
  logic       r_done;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      IDLE: begin
        if (rst_req) begin
          w_state_nxt = ASSERT;
          w_cnt_nxt   = MIN_LOAD;
        end
      end
      ASSERT: begin
        // Minimum hold first; afterwards the request level extends the reset.
        if (r_cnt != '0) begin
          w_cnt_nxt = r_cnt - 8'd1;
        end else if (!rst_req) begin
          w_state_nxt = RELEASE;
          w_cnt_nxt   = REL_LOAD;
        end
      end
      RELEASE: begin
        if (rst_req) begin
          w_state_nxt = ASSERT;
          w_cnt_nxt   = MIN_LOAD;
        end else if (r_cnt != '0) begin
          w_cnt_nxt = r_cnt - 8'd1;
        end else begin
          w_state_nxt = DONE;
        end
      end
      DONE: begin
        if (rst_req) begin
          w_state_nxt = ASSERT;
          w_cnt_nxt   = MIN_LOAD;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // Outputs are registered from the next state so they change on the same
  // edge as the state itself, with no combinational path from rst_req.
  always_ff @(posedge i_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_sft_rst_n <= 1'b1;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_sft_rst_n <= (w_state_nxt != ASSERT);
      r_busy      <= (w_state_nxt != IDLE);
      r_done      <= (w_state_nxt == DONE);
    end
  end

  assign sft_rst_n   = r_sft_rst_n | testmode;
  assign ker_clk_req = per_ker_clk_req_in | (r_state == ASSERT);
  assign rst_busy    = r_busy;
  assign rst_done    = r_done;

endmodule
